// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the writeback unit: XLEN, load funct3 encodings and
// the WBU state type.
package ysyx_22050243_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wbu_state_t;

endpackage

// File: rtl/ysyx_22050243_load_ext.sv
// Picks the addressed lane out of an aligned doubleword and sign- or
// zero-extends it according to the load funct3.
module ysyx_22050243_load_ext
   import ysyx_22050243_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN
) (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [2:0]            funct3,
   input  logic [2:0]            off,
   output logic [DATA_WIDTH-1:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] word_lane;

   // Low offset bits below the access size are ignored, so misaligned
   // offsets fall back to the naturally aligned lane.
   always_comb begin
      byte_lane = rdata[{off, 3'b000} +: 8];
      half_lane = rdata[{off[2:1], 4'b0000} +: 16];
      word_lane = rdata[{off[2], 5'b00000} +: 32];
   end

   always_comb begin
      data = rdata;
      case (funct3)
         LB:      data = {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
         LH:      data = {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
         LW:      data = {{(DATA_WIDTH-32){word_lane[31]}}, word_lane};
         LBU:     data = {{(DATA_WIDTH-8){1'b0}}, byte_lane};
         LHU:     data = {{(DATA_WIDTH-16){1'b0}}, half_lane};
         LWU:     data = {{(DATA_WIDTH-32){1'b0}}, word_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/ysyx_22050243_wbu.sv
// Writeback unit: retires EXU results and load returns into registered GPR
// write pulses, a commit pulse, and a pending-load-destination flag.
module ysyx_22050243_wbu
   import ysyx_22050243_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = XLEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic [DATA_WIDTH-1:0] ex_pc,
   input  logic [ADDR_WIDTH-1:0] ex_rd,
   input  logic                  ex_rd_wen,
   input  logic [DATA_WIDTH-1:0] ex_result,
   input  logic                  ex_is_load,
   input  logic [2:0]            ex_ld_funct3,
   input  logic [2:0]            ex_ld_off,
   input  logic                  lsu_rvalid,
   input  logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  lsu_rready,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  commit_valid,
   output logic [DATA_WIDTH-1:0] commit_pc,
   output logic                  pend_valid,
   output logic [ADDR_WIDTH-1:0] pend_rd
);

   wbu_state_t            state;
   logic [DATA_WIDTH-1:0] ld_pc;
   logic [ADDR_WIDTH-1:0] ld_rd;
   logic                  ld_rd_wen;
   logic [2:0]            ld_funct3;
   logic [2:0]            ld_off;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  ex_we;
   logic                  ld_we;

   assign ex_ready   = (state == IDLE);
   assign lsu_rready = (state == WAIT_LOAD);
   assign ex_we      = ex_rd_wen && (ex_rd != '0);
   assign ld_we      = ld_rd_wen && (ld_rd != '0);

   ysyx_22050243_load_ext #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_ext (
      .rdata  (lsu_rdata),
      .funct3 (ld_funct3),
      .off    (ld_off),
      .data   (ld_data)
   );

   // w_addr/w_data only move on an actual write so they hold while w_en=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         w_en         <= 1'b0;
         w_addr       <= '0;
         w_data       <= '0;
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         pend_valid   <= 1'b0;
         pend_rd      <= '0;
         ld_pc        <= '0;
         ld_rd        <= '0;
         ld_rd_wen    <= 1'b0;
         ld_funct3    <= '0;
         ld_off       <= '0;
      end else begin
         w_en         <= 1'b0;
         commit_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (!ex_is_load) begin
                     w_en         <= ex_we;
                     commit_valid <= 1'b1;
                     commit_pc    <= ex_pc;
                     if (ex_we) begin
                        w_addr <= ex_rd;
                        w_data <= ex_result;
                     end
                  end else begin
                     state      <= WAIT_LOAD;
                     ld_pc      <= ex_pc;
                     ld_rd      <= ex_rd;
                     ld_rd_wen  <= ex_rd_wen;
                     ld_funct3  <= ex_ld_funct3;
                     ld_off     <= ex_ld_off;
                     pend_valid <= ex_we;
                     pend_rd    <= ex_rd;
                  end
               end
            end
            WAIT_LOAD: begin
               if (lsu_rvalid) begin
                  state        <= IDLE;
                  w_en         <= ld_we;
                  commit_valid <= 1'b1;
                  commit_pc    <= ld_pc;
                  pend_valid   <= 1'b0;
                  if (ld_we) begin
                     w_addr <= ld_rd;
                     w_data <= ld_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ysyx_22050243_wbu.md
Name: ysyx_22050243_wbu

Overview:
Writeback unit sitting directly upstream of the general-purpose register file (GPR). It accepts retiring instructions from EXU over a valid/ready handshake. For loads, it waits for the LSU read response, then lane-selects and sign- or zero-extends the data. It drives the GPR write port with registered, single-cycle write pulses, and also emits a commit pulse (for difftest) plus a pending-rd indication used by the decode interlock.

Parameters:
ADDR_WIDTH, 5, GPR index width.
DATA_WIDTH, 64, XLEN; 64 is the only supported value (LD/LWU are RV64).

Ports:
clk  in  1  clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EXU presents a retiring instruction
ex_ready  out  1  WBU can accept; combinational, equals (state==IDLE)
ex_pc  in  DATA_WIDTH  instruction PC
ex_rd  in  ADDR_WIDTH  destination register
ex_rd_wen  in  1  instruction writes rd
ex_result  in  DATA_WIDTH  ALU/CSR/jump-link result
ex_is_load  in  1  result comes from LSU, not ex_result
ex_ld_funct3  in  3  load type
ex_ld_off  in  3  effective address bits [2:0]
lsu_rvalid  in  1  load data valid
lsu_rdata  in  DATA_WIDTH  aligned 8-byte doubleword containing the datum
lsu_rready  out  1  equals (state==WAIT_LOAD)
w_en  out  1  GPR write enable (registered)
w_addr  out  ADDR_WIDTH  GPR write index (registered)
w_data  out  DATA_WIDTH  GPR write data (registered)
commit_valid  out  1  one-cycle pulse per retired instruction
commit_pc  out  DATA_WIDTH  PC of the committed instruction
pend_valid  out  1  a load destination is outstanding
pend_rd  out  ADDR_WIDTH  that destination register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - w_en=0, w_addr=0, w_data=0.
  - commit_valid=0, commit_pc=0.
  - pend_valid=0, pend_rd=0.
  - Latched load context cleared.
- States: IDLE and WAIT_LOAD.
- IDLE, handshake with ex_is_load=0:
  - Next cycle: w_en=ex_rd_wen&&(ex_rd!=0), w_addr=ex_rd, w_data=ex_result, commit_valid=1, commit_pc=ex_pc.
  - State stays IDLE, so back-to-back non-loads sustain 1 per cycle; latency is 1 cycle.
- IDLE, handshake with ex_is_load=1:
  - Latch pc, rd, rd_wen, funct3, off. Go to WAIT_LOAD; no write or commit that cycle.
  - From the next cycle: pend_valid=(rd_wen&&rd!=0), pend_rd=rd.
- WAIT_LOAD:
  - ex_ready=0 and lsu_rready=1.
  - On lsu_rvalid, next cycle: w_en=(rd_wen&&rd!=0), w_data=ext(lsu_rdata), commit_valid=1, pend_valid=0, state=IDLE.
  - Waiting is unbounded; no timeout.
- Load extension, with byte lane = off:
  - 000 LB: sign-extend 8 bits.
  - 001 LH: sign-extend 16 bits; off[0] ignored.
  - 010 LW: sign-extend 32 bits; off[1:0] ignored.
  - 011 LD: full 64 bits; off ignored.
  - 100 LBU, 101 LHU, 110 LWU: same lanes as the signed forms, zero-extended.
  - 111: treated as LD.
- Every w_en, commit_valid and w_en pulse lasts exactly one cycle unless a new commit follows; w_addr/w_data hold their last values when w_en=0.
- rd=x0: the instruction still commits (commit_valid=1), but w_en=0.
- lsu_rvalid in IDLE: ignored; no state change.
- ex_valid while ex_ready=0: not accepted; EXU holds its inputs stable.
- Reset asserted in WAIT_LOAD: the load is abandoned immediately; a late lsu_rvalid after reset is ignored (IDLE).
- Forwarding: the GPR forwards w_data during a w_en cycle, so decode stalls only on pend_valid, never on w_en.

Decomposition:
- Package ysyx_22050243_pkg holds:
  - XLEN.
  - Load funct3 constants: LB, LH, LW, LD, LBU, LHU, LWU.
  - WBU state enum: IDLE, WAIT_LOAD.
- Sub-module ysyx_22050243_load_ext: purely combinational lane-select and extend; inputs rdata, funct3, off; output DATA_WIDTH.

Test Plan:
- ALU write: ex_valid=1 with rd=5, result=0x1234, pc=0x80000000 → next cycle w_en=1, w_addr=5, w_data=0x1234, commit_valid=1, commit_pc=0x80000000.
- Back-to-back: three non-loads to rd=1,2,3 on consecutive cycles → ex_ready stays 1; three consecutive w_en pulses in order.
- LB sign and LBU zero: off=3, lsu_rdata=0x00000000_80FF0000, arriving 4 cycles after accept → ex_ready=0 and pend_valid=1, pend_rd=rd while waiting.
  - LB: w_data=0xFFFFFFFF_FFFFFF80.
  - LBU: w_data=0x80.
- LW on the upper lane: off=4, rdata=0xDEADBEEF_00000000 → w_data=0xFFFFFFFF_DEADBEEF. Same with LWU → 0x00000000_DEADBEEF.
- x0 destination: load to rd=0 → pend_valid=0, w_en=0 on return, commit_valid=1.
- Reset mid-load: rst_n low during WAIT_LOAD, then a stray lsu_rvalid → no w_en, no commit, ex_ready=1 immediately after reset release.
